atm_pin_entry: RTL and testbench

Keypad front end for the ATM control FSM. It collects PIN digits from a strobed keypad, checks them against a stored PIN, counts failed attempts and handles lockout and inactivity timeout. It sends one 3-bit command token per outcome to the downstream ATM transaction FSM over a valid/ready handshake.

---
 rtl/atm_pin_entry.sv | 214 +++++++++++++++++++++
 tb/tb_atm_pin_entry.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_pin_entry.sv
// atm_pin_entry: keypad front end for the ATM control FSM. Collects PIN digits,
// checks them against PIN_VALUE, counts failed attempts, handles lockout and
// inactivity timeout, and hands one command token per outcome downstream over
// a valid/ready handshake.
// Build option: define ATM_LOCK_RELEASE_EN to let LOCKED release itself after
// LOCK_CYCLES cycles; without it LOCKED is left only by reset.
module atm_pin_entry #(
  parameter int          PIN_DIGITS     = 4,
  parameter logic [15:0] PIN_VALUE      = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          LOCK_CYCLES    = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       card_in,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_out,
  output logic       locked,
  output logic [2:0] digit_count,
  output logic       busy
);

  localparam int            PW          = 4 * PIN_DIGITS;
  localparam int            TW          = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    DIGITS_FULL = 3'(PIN_DIGITS);
  localparam logic [2:0]    TRIES_LIMIT = 3'(MAX_TRIES);

  localparam logic [2:0] TOK_OK      = 3'b000;
  localparam logic [2:0] TOK_BAD     = 3'b001;
  localparam logic [2:0] TOK_CANCEL  = 3'b010;
  localparam logic [2:0] TOK_LOCK    = 3'b011;
  localparam logic [2:0] TOK_TIMEOUT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_EMIT,
    S_LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    tries_q, tries_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    tok_q, tok_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          busy_q, busy_d;
  logic          locked_q, locked_d;

`ifdef ATM_LOCK_RELEASE_EN
  localparam int            LW        = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  logic [LW-1:0] lock_q, lock_d;
`else
  // No lock counter in this build; the parameter is only referenced here.
  logic unused_lock_cycles;
  assign unused_lock_cycles = (LOCK_CYCLES != 0);
`endif

  // Keys 0..C are real keypad activity; D..F are treated as noise.
  logic key_active;
  logic key_is_digit;
  logic pin_match;
  logic [2:0] tries_inc;

  assign key_active   = key_valid && (key_code <= 4'hC);
  assign key_is_digit = (key_code <= 4'd9);
  assign pin_match    = (buf_q[PW-1:0] == PIN_VALUE[PW-1:0]);
  assign tries_inc    = tries_q + 3'd1;

  // State register and all registered outputs; async active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      tries_q     <= '0;
      tmo_q       <= '0;
      tok_q       <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
`ifdef ATM_LOCK_RELEASE_EN
      lock_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      tmo_q       <= tmo_d;
      tok_q       <= tok_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
`ifdef ATM_LOCK_RELEASE_EN
      lock_q      <= lock_d;
`endif
    end
  end

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    tmo_d   = tmo_q;
    tok_d   = tok_q;
`ifdef ATM_LOCK_RELEASE_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (card_in) begin
          state_d = S_COLLECT;
          buf_d   = '0;
          cnt_d   = '0;
          tries_d = '0;
          tmo_d   = '0;
        end
      end
      S_COLLECT: begin
        // Card removal beats any key arriving in the same cycle.
        if (!card_in) begin
          tok_d   = TOK_CANCEL;
          state_d = S_EMIT;
        end else if (key_active) begin
          tmo_d = '0;
          if (key_is_digit) begin
            if (cnt_q < DIGITS_FULL) begin
              buf_d = {buf_q[11:0], key_code};
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_code == 4'hA) begin
            buf_d = '0;
            cnt_d = '0;
          end else if (key_code == 4'hB) begin
            if (cnt_q == DIGITS_FULL) begin
              state_d = S_CHECK;
            end
          end else begin
            tok_d   = TOK_CANCEL;
            state_d = S_EMIT;
          end
        end else if (tmo_q == TMO_LAST) begin
          tok_d   = TOK_TIMEOUT;
          state_d = S_EMIT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        state_d = S_EMIT;
        if (pin_match) begin
          tries_d = '0;
          tok_d   = TOK_OK;
        end else begin
          tries_d = tries_inc;
          tok_d   = (tries_inc == TRIES_LIMIT) ? TOK_LOCK : TOK_BAD;
        end
      end
      S_EMIT: begin
        if (cmd_ready) begin
          case (tok_q)
            TOK_BAD: begin
              state_d = S_COLLECT;
              buf_d   = '0;
              cnt_d   = '0;
              tmo_d   = '0;
            end
            TOK_LOCK: begin
              state_d = S_LOCKED;
`ifdef ATM_LOCK_RELEASE_EN
              lock_d  = '0;
`endif
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LOCKED: begin
`ifdef ATM_LOCK_RELEASE_EN
        if (lock_q == LOCK_LAST) begin
          state_d = S_IDLE;
          tries_d = '0;
        end else begin
          lock_d = lock_q + LW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the state being entered.
    cmd_valid_d = (state_d == S_EMIT);
    busy_d      = (state_d != S_IDLE);
    locked_d    = (state_d == S_LOCKED);
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_out     = tok_q;
  assign locked      = locked_q;
  assign digit_count = cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Self-checking bench for atm_pin_entry: a vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
// Honours ATM_LOCK_RELEASE_EN when the design is built with it.
module tb_atm_pin_entry;

  localparam int          TMO      = 1000;
  localparam int          LOCK_CYC = 20;
  localparam int          TRIES    = 3;
  localparam logic [15:0] PIN      = 16'h1234;

  logic       clock;
  logic       reset;
  logic       card_in;
  logic       key_valid;
  logic [3:0] key_code;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_out;
  logic       locked;
  logic [2:0] digit_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  atm_pin_entry #(
    .PIN_DIGITS    (4),
    .PIN_VALUE     (PIN),
    .MAX_TRIES     (TRIES),
    .TIMEOUT_CYCLES(TMO),
    .LOCK_CYCLES   (LOCK_CYC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .card_in    (card_in),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_out    (cmd_out),
    .locked     (locked),
    .digit_count(digit_count),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  // A session holds a list of entered digits; an outcome is a pending token
  // that sits until the consumer takes it.
  int dig_q[$];
  bit m_session;
  bit m_checking;
  bit m_locked;
  int m_pending;
  int m_last;
  int m_tries;
  int m_idle;
  int m_cycle;
`ifdef ATM_LOCK_RELEASE_EN
  int m_lock_left;
`endif

  task automatic model_reset();
    dig_q.delete();
    m_session  = 0;
    m_checking = 0;
    m_locked   = 0;
    m_pending  = -1;
    m_last     = 0;
    m_tries    = 0;
    m_idle     = 0;
`ifdef ATM_LOCK_RELEASE_EN
    m_lock_left = 0;
`endif
  endtask

  task automatic model_emit(input int tok);
    m_pending = tok;
    m_last    = tok;
    m_session = 0;
  endtask

  task automatic model_edge(input bit c, input bit kv, input int kc, input bit rdy);
    int value;
    if (m_pending >= 0) begin
      if (rdy) begin
        $display("token %0d handed over at cycle %0d", m_pending, m_cycle);
        if (m_pending == 1) begin
          m_session = 1;
          dig_q.delete();
          m_idle = 0;
        end else if (m_pending == 3) begin
          m_locked = 1;
`ifdef ATM_LOCK_RELEASE_EN
          m_lock_left = LOCK_CYC;
`endif
        end
        m_pending = -1;
      end
    end else if (m_checking) begin
      m_checking = 0;
      value = 0;
      foreach (dig_q[i]) value = value * 16 + dig_q[i];
      if (value == int'(PIN)) begin
        m_tries = 0;
        model_emit(0);
      end else begin
        m_tries++;
        model_emit((m_tries == TRIES) ? 3 : 1);
      end
    end else if (m_locked) begin
`ifdef ATM_LOCK_RELEASE_EN
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_locked = 0;
        m_tries  = 0;
      end
`endif
    end else if (m_session) begin
      if (!c) begin
        model_emit(2);
      end else if (kv && kc <= 12) begin
        m_idle = 0;
        if (kc <= 9) begin
          if (dig_q.size() < 4) dig_q.push_back(kc);
        end else if (kc == 10) begin
          dig_q.delete();
        end else if (kc == 11) begin
          if (dig_q.size() == 4) begin
            m_session  = 0;
            m_checking = 1;
          end
        end else begin
          model_emit(2);
        end
      end else if (m_idle == TMO - 1) begin
        model_emit(4);
      end else begin
        m_idle++;
      end
    end else if (c) begin
      m_session = 1;
      dig_q.delete();
      m_tries = 0;
      m_idle  = 0;
    end
    m_cycle++;
  endtask

  function automatic logic [8:0] model_outs();
    logic pend;
    pend = (m_pending >= 0);
    return {pend, 3'(m_last), m_locked, 3'(dig_q.size()),
            m_session | m_checking | pend | m_locked};
  endfunction

  function automatic logic [8:0] dut_outs();
    return {cmd_valid, cmd_out, locked, digit_count, busy};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit c, input bit kv, input logic [3:0] kc, input bit rdy);
    card_in   = c;
    key_valid = kv;
    key_code  = kc;
    cmd_ready = rdy;
    @(posedge clock);
    model_edge(c, kv, int'(kc), rdy);
    #1;
    chk("model", int'(dut_outs()), int'(model_outs()));
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    card_in   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    cmd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", int'(dut_outs()), 0);
    #1 reset = 1'b1;
  endtask

  task automatic enter_pin(input logic [15:0] pin, input int exp_tok, input string tag);
    int n;
    for (int i = 3; i >= 0; i--) tick(1, 1, pin[4*i +: 4], 0);
    tick(1, 1, 4'hB, 0);
    n = 0;
    while (!cmd_valid && n < 5) begin
      tick(1, 0, 4'h0, 0);
      n++;
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_token"}, int'(cmd_out), exp_tok);
    tick(1, 0, 4'h0, 1);
    chk({tag, "_drop"}, int'(cmd_valid), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         card;
    bit         kv;
    logic [3:0] kc;
    bit         rdy;
    bit         ev;
    logic [2:0] eo;
    bit         el;
    logic [2:0] ec;
    bit         eb;
  } vec_t;

  vec_t tab[$];

  task automatic add(input bit c, input bit kv, input logic [3:0] kc, input bit rdy,
                     input bit ev, input logic [2:0] eo, input bit el,
                     input logic [2:0] ec, input bit eb);
    vec_t v;
    v.card = c;  v.kv = kv; v.kc = kc; v.rdy = rdy;
    v.ev   = ev; v.eo = eo; v.el = el; v.ec = ec;  v.eb = eb;
    tab.push_back(v);
  endtask

  initial begin
    int         n;
    int         sel;
    int         lock_run;
    bit         c;
    bit         kv;
    bit         r;
    logic [3:0] kc;
    logic [15:0] pin_v;

    pin_v = PIN;
    m_cycle = 0;
    reset = 1'b0;
    do_reset();

    // card, key_valid, key, ready | valid, token, locked, digits, busy
    add(1,0,4'h0,0, 0,3'd0,0,3'd0,1);  // insert card
    add(1,1,4'h1,0, 0,3'd0,0,3'd1,1);
    add(1,1,4'h2,0, 0,3'd0,0,3'd2,1);
    add(1,1,4'hA,0, 0,3'd0,0,3'd0,1);  // clear
    add(1,1,4'h1,0, 0,3'd0,0,3'd1,1);
    add(1,1,4'h2,0, 0,3'd0,0,3'd2,1);
    add(1,1,4'h3,0, 0,3'd0,0,3'd3,1);
    add(1,1,4'hB,0, 0,3'd0,0,3'd3,1);  // enter with 3 digits: ignored
    add(1,1,4'h4,0, 0,3'd0,0,3'd4,1);
    add(1,1,4'h9,0, 0,3'd0,0,3'd4,1);  // fifth digit ignored
    add(1,1,4'hE,0, 0,3'd0,0,3'd4,1);  // noise code
    add(1,1,4'hB,0, 0,3'd0,0,3'd4,1);  // enter -> check
    add(1,0,4'h0,0, 1,3'd0,0,3'd4,1);  // PIN_OK pending
    add(1,0,4'h0,0, 1,3'd0,0,3'd4,1);
    add(1,0,4'h0,1, 0,3'd0,0,3'd4,0);  // accepted -> idle
    add(1,0,4'h0,0, 0,3'd0,0,3'd0,1);  // new session
    add(1,1,4'h1,0, 0,3'd0,0,3'd1,1);
    add(1,1,4'h2,0, 0,3'd0,0,3'd2,1);
    add(1,1,4'h3,0, 0,3'd0,0,3'd3,1);
    add(1,1,4'h5,0, 0,3'd0,0,3'd4,1);
    add(1,1,4'hB,0, 0,3'd0,0,3'd4,1);
    add(1,0,4'h0,0, 1,3'd1,0,3'd4,1);  // PIN_BAD held under backpressure
    add(1,0,4'h0,0, 1,3'd1,0,3'd4,1);
    add(1,0,4'h0,0, 1,3'd1,0,3'd4,1);
    add(1,0,4'h0,0, 1,3'd1,0,3'd4,1);
    add(1,0,4'h0,0, 1,3'd1,0,3'd4,1);
    add(1,0,4'h0,1, 0,3'd1,0,3'd0,1);  // accepted -> collect, cleared
    add(1,1,4'h1,0, 0,3'd1,0,3'd1,1);
    add(1,1,4'h2,0, 0,3'd1,0,3'd2,1);
    add(1,1,4'h3,0, 0,3'd1,0,3'd3,1);
    add(1,1,4'h4,0, 0,3'd1,0,3'd4,1);
    add(1,1,4'hB,0, 0,3'd1,0,3'd4,1);
    add(1,0,4'h0,1, 1,3'd0,0,3'd4,1);  // ready already high on entry
    add(1,0,4'h0,1, 0,3'd0,0,3'd4,0);  // valid lasted one cycle
    add(1,0,4'h0,0, 0,3'd0,0,3'd0,1);
    add(0,1,4'h7,0, 1,3'd2,0,3'd0,1);  // card removal beats digit
    add(0,0,4'h0,1, 0,3'd2,0,3'd0,0);

    foreach (tab[i]) begin
      tick(tab[i].card, tab[i].kv, tab[i].kc, tab[i].rdy);
      chk($sformatf("vec%0d", i), int'(dut_outs()),
          int'({tab[i].ev, tab[i].eo, tab[i].el, tab[i].ec, tab[i].eb}));
    end

    // Lockout after three consecutive bad PINs.
    do_reset();
    tick(1, 0, 4'h0, 0);
    enter_pin(16'h1235, 1, "try1");
    enter_pin(16'h9999, 1, "try2");
    enter_pin(16'h4321, 3, "try3");
    chk("locked_set", int'(locked), 1);
`ifdef ATM_LOCK_RELEASE_EN
    n = 0;
    do begin
      tick(1'($urandom_range(0, 1)), 1, 4'($urandom_range(0, 15)), 1);
      n++;
      if (locked) chk("locked_quiet", int'(cmd_valid), 0);
    end while (locked && n < 100);
    chk("lock_release_cycles", n, LOCK_CYC);
    chk("release_busy", int'(busy), 0);
    tick(1, 0, 4'h0, 0);
    enter_pin(PIN, 0, "after_release");
`else
    for (int i = 0; i < 12; i++) begin
      tick(1'(i % 2), 1, 4'($urandom_range(0, 15)), 1);
      chk("locked_quiet", int'({cmd_valid, locked}), 1);
    end
    do_reset();
    chk("locked_cleared", int'(locked), 0);
`endif

    // Inactivity timeout; D..F codes do not count as activity.
    do_reset();
    tick(1, 0, 4'h0, 0);
    n = 0;
    while (!cmd_valid && n < TMO + 50) begin
      tick(1, ($urandom_range(0, 3) == 0), 4'(13 + $urandom_range(0, 2)), 0);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_token", int'(cmd_out), 4);
    tick(1, 0, 4'h0, 1);

    // Asynchronous reset while a token is pending drops it at once.
    do_reset();
    tick(1, 0, 4'h0, 0);
    for (int i = 3; i >= 0; i--) tick(1, 1, pin_v[4*i +: 4], 0);
    tick(1, 1, 4'hB, 0);
    tick(1, 0, 4'h0, 0);
    chk("pending_before_reset", int'(cmd_valid), 1);
    reset = 1'b0;
    #1;
    chk("async_reset", int'(dut_outs()), 0);
    model_reset();
    @(posedge clock);
    #2 reset = 1'b1;

    // Randomized run against the model.
    lock_run = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (lock_run > 30 || $urandom_range(0, 399) == 0) begin
        do_reset();
        lock_run = 0;
      end
      c   = ($urandom_range(0, 99) < 98);
      kv  = ($urandom_range(0, 99) < 45);
      r   = ($urandom_range(0, 99) < 60);
      sel = int'($urandom_range(0, 99));
      if (sel < 35 && dig_q.size() < 4)
        kc = pin_v[4*(3 - int'(dig_q.size())) +: 4];
      else if (sel < 65) kc = 4'($urandom_range(0, 9));
      else if (sel < 72) kc = 4'hA;
      else if (sel < 88) kc = 4'hB;
      else if (sel < 91) kc = 4'hC;
      else               kc = 4'(13 + $urandom_range(0, 2));
      tick(c, kv, kc, r);
      lock_run = m_locked ? lock_run + 1 : 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
